updown_step_counter: RTL and testbench

Parametrised synchronous up/down counter with programmable step, parallel load, a configurable modulus, and a wrap or saturate boundary mode. It is the registered successor to the team's combinational ripple incrementor/decrementor cells. It serves as the general counting primitive for timers, address generators and loop counters in the arithmetic library.

---
 rtl/arith_pkg.sv | 18 +
 rtl/updown_step_counter_if.sv | 26 ++
 rtl/updown_step_counter_addsub_step.sv | 32 +++
 rtl/updown_step_counter.sv | 94 +++++++++
 tb/tb_updown_step_counter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-library constants and elaboration helpers.
package arith_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  localparam int N_MIN = 4;
  localparam int N_MAX = 16;

  function automatic bit n_legal(input int n);
    return (n >= N_MIN) && (n <= N_MAX);
  endfunction

  function automatic bit max_legal(input int n, input int max_val);
    return (max_val >= 1) && (max_val <= (1 << n) - 1);
  endfunction

endpackage

// File: rtl/updown_step_counter_if.sv
// Control and status bundle for updown_step_counter.
interface updown_step_counter_if #(
  parameter int N = 8
);

  logic         en;
  logic         up;
  logic [N-1:0] step;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] count;
  logic         zero;
  logic         at_max;
  logic         ovf;

  modport master (
    output en, up, step, load, load_val,
    input  count, zero, at_max, ovf
  );

  modport slave (
    input  en, up, step, load, load_val,
    output count, zero, at_max, ovf
  );

endinterface

// File: rtl/updown_step_counter_addsub_step.sv
// Combinational N-bit ripple add/subtract with an N+1-bit result.
// up=1: res = a + b, cout = carry out.
// up=0: res = a - b modulo 2**(N+1), cout = borrow (a < b).
module addsub_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         up,
  output logic [N:0]   res,
  output logic         cout
);

  logic [N:0]   c;
  logic [N-1:0] bx;
  logic [N-1:0] sum;

  // Ripple chain; subtraction is a + ~b + 1, borrow is the inverted carry
  always_comb begin
    bx   = up ? b : ~b;
    c    = '0;
    c[0] = ~up;
    sum  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
    cout = up ? c[N] : ~c[N];
    res  = {cout, sum};
  end

endmodule

// File: rtl/updown_step_counter.sv
// Registered up/down counter with programmable step, parallel load,
// configurable terminal count and wrap/saturate boundary handling.
module updown_step_counter
  import arith_pkg::*;
#(
  parameter int N       = 8,
  parameter int MAX_VAL = (1 << N) - 1,
  parameter int MODE    = MODE_WRAP
) (
  input logic                  clk,
  input logic                  rst_n,
  updown_step_counter_if.slave bus
);

  localparam logic [N-1:0] MAXN = N'(MAX_VAL);
  localparam logic [N:0]   MAXW = (N+1)'(MAX_VAL);
  localparam logic [N:0]   MODW = (N+1)'(MAX_VAL + 1);

  if (!n_legal(N)) begin : g_bad_n
    $error("updown_step_counter: N=%0d outside 4..16", N);
  end
  if (!max_legal(N, MAX_VAL)) begin : g_bad_max
    $error("updown_step_counter: MAX_VAL=%0d outside 1..2**N-1", MAX_VAL);
  end
  if (MODE != MODE_WRAP && MODE != MODE_SAT) begin : g_bad_mode
    $error("updown_step_counter: MODE=%0d unknown", MODE);
  end

  logic [N-1:0] count_q;
  logic         ovf_q;
  logic [N-1:0] s;
  logic [N-1:0] lv;
  logic [N:0]   res;
  logic         brw;
  logic [N-1:0] count_nxt;
  logic         ovf_nxt;

  // Clamp step and load value into the legal count range
  always_comb begin
    s  = (bus.step     > MAXN) ? MAXN : bus.step;
    lv = (bus.load_val > MAXN) ? MAXN : bus.load_val;
  end

  addsub_step #(.N(N)) u_addsub (
    .a    (count_q),
    .b    (s),
    .up   (bus.up),
    .res  (res),
    .cout (brw)
  );

  // Next-state select: load > en > hold, with boundary wrap or clip
  always_comb begin
    count_nxt = count_q;
    ovf_nxt   = 1'b0;
    if (bus.load) begin
      count_nxt = lv;
    end else if (bus.en) begin
      if (bus.up) begin
        if (res > MAXW) begin
          ovf_nxt   = 1'b1;
          count_nxt = (MODE == MODE_SAT) ? MAXN : N'(res - MODW);
        end else begin
          count_nxt = res[N-1:0];
        end
      end else begin
        // res holds count - s modulo 2**(N+1); adding the modulus folds it back
        if (brw) begin
          ovf_nxt   = 1'b1;
          count_nxt = (MODE == MODE_SAT) ? '0 : N'(res + MODW);
        end else begin
          count_nxt = res[N-1:0];
        end
      end
    end
  end

  // Count and overflow-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      ovf_q   <= ovf_nxt;
    end
  end

  assign bus.count  = count_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = (count_q == '0);
  assign bus.at_max = (count_q == MAXN);

endmodule

// File: tb/tb_updown_step_counter.sv
// Directed and random checks for updown_step_counter: a 4-bit wrap and
// saturate instance (MAX_VAL=9) plus an 8-bit full-range wrap instance.
module tb_updown_step_counter;
  import arith_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_w, rst_s, rst_8;

  updown_step_counter_if #(.N(4)) bw();
  updown_step_counter_if #(.N(4)) bs();
  updown_step_counter_if #(.N(8)) b8();

  updown_step_counter #(.N(4), .MAX_VAL(9), .MODE(MODE_WRAP)) u_wrap (
    .clk(clk), .rst_n(rst_w), .bus(bw.slave));
  updown_step_counter #(.N(4), .MAX_VAL(9), .MODE(MODE_SAT)) u_sat (
    .clk(clk), .rst_n(rst_s), .bus(bs.slave));
  updown_step_counter #(.N(8), .MAX_VAL(255), .MODE(MODE_WRAP)) u_full (
    .clk(clk), .rst_n(rst_8), .bus(b8.slave));

  typedef struct {
    string tag;
    int    cnt;
    bit    ovf;
    bit    zero;
    bit    atmax;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input string tag, input int c, input bit o, input bit z, input bit m);
    exp_t e;
    e.tag = tag; e.cnt = c; e.ovf = o; e.zero = z; e.atmax = m;
    sb.push_back(e);
  endtask

  task automatic check(input int oc, input bit oo, input bit oz, input bit om);
    exp_t e;
    n_cmp++;
    assert (sb.size() > 0) else begin
      n_bad++;
      $error("FAIL scoreboard_empty: got 0 entries, expected at least 1");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    assert (oc === e.cnt) else begin
      n_bad++; $error("FAIL %s count: got %0d expected %0d", e.tag, oc, e.cnt);
    end
    n_cmp++;
    assert (oo === e.ovf) else begin
      n_bad++; $error("FAIL %s ovf: got %0b expected %0b", e.tag, oo, e.ovf);
    end
    n_cmp++;
    assert (oz === e.zero) else begin
      n_bad++; $error("FAIL %s zero: got %0b expected %0b", e.tag, oz, e.zero);
    end
    n_cmp++;
    assert (om === e.atmax) else begin
      n_bad++; $error("FAIL %s at_max: got %0b expected %0b", e.tag, om, e.atmax);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_w(input bit l, input int lv, input bit e, input bit u, input int st);
    bw.load = l; bw.load_val = 4'(lv); bw.en = e; bw.up = u; bw.step = 4'(st);
  endtask

  task automatic drv_s(input bit l, input int lv, input bit e, input bit u, input int st);
    bs.load = l; bs.load_val = 4'(lv); bs.en = e; bs.up = u; bs.step = 4'(st);
  endtask

  task automatic drv_8(input bit l, input int lv, input bit e, input bit u, input int st);
    b8.load = l; b8.load_val = 8'(lv); b8.en = e; b8.up = u; b8.step = 8'(st);
  endtask

  task automatic run_w(input string tag, input bit l, input int lv, input bit e,
                       input bit u, input int st, input int ec, input bit eo);
    drv_w(l, lv, e, u, st);
    push(tag, ec, eo, ec == 0, ec == 9);
    tick();
    check(int'(bw.count), bw.ovf, bw.zero, bw.at_max);
  endtask

  task automatic run_s(input string tag, input bit l, input int lv, input bit e,
                       input bit u, input int st, input int ec, input bit eo);
    drv_s(l, lv, e, u, st);
    push(tag, ec, eo, ec == 0, ec == 9);
    tick();
    check(int'(bs.count), bs.ovf, bs.zero, bs.at_max);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, t, st;
    bit u, e, eo;

    rst_w = 1'b0; rst_s = 1'b0; rst_8 = 1'b0;
    drv_w(0, 0, 0, 0, 0);
    drv_s(0, 0, 0, 0, 0);
    drv_8(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_w = 1'b1; rst_s = 1'b1; rst_8 = 1'b1;

    // Reset state of every instance
    push("rst_wrap", 0, 0, 1, 0); check(int'(bw.count), bw.ovf, bw.zero, bw.at_max);
    push("rst_sat",  0, 0, 1, 0); check(int'(bs.count), bs.ovf, bs.zero, bs.at_max);
    push("rst_full", 0, 0, 1, 0); check(int'(b8.count), b8.ovf, b8.zero, b8.at_max);
    tick();

    // Wrap mode, MAX_VAL=9
    run_w("w_load8",        1, 8,  0, 0, 0,  8, 0);
    run_w("w_up_wrap",      0, 0,  1, 1, 3,  1, 1);
    run_w("w_idle",         0, 0,  0, 0, 0,  1, 0);
    run_w("w_dn_wrap",      0, 0,  1, 0, 4,  7, 1);
    run_w("w_load0",        1, 0,  0, 0, 0,  0, 0);
    run_w("w_dn1_from0",    0, 0,  1, 0, 1,  9, 1);
    run_w("w_ld_pri_clamp", 1, 14, 1, 1, 3,  9, 0);
    run_w("w_ld3",          1, 3,  1, 0, 1,  3, 0);
    run_w("w_step0",        0, 0,  1, 1, 0,  3, 0);
    run_w("w_step_clamp",   0, 0,  1, 1, 15, 2, 1);
    run_w("w_up_to_max",    0, 0,  1, 1, 7,  9, 0);
    run_w("w_dn_to_zero",   0, 0,  1, 0, 9,  0, 0);
    run_w("w_ld8",          1, 8,  0, 0, 0,  8, 0);
    run_w("w_wrap_to7",     0, 0,  1, 1, 9,  7, 1);

    // Asynchronous reset mid-cycle, sampled with no clock edge in between
    drv_w(0, 0, 1, 1, 1);
    #2;
    rst_w = 1'b0;
    #1;
    push("w_async_rst", 0, 0, 1, 0);
    check(int'(bw.count), bw.ovf, bw.zero, bw.at_max);
    drv_w(0, 0, 0, 0, 0);
    @(negedge clk);
    rst_w = 1'b1;
    tick();
    push("w_after_rst", 0, 0, 1, 0);
    check(int'(bw.count), bw.ovf, bw.zero, bw.at_max);

    // Saturate mode, MAX_VAL=9
    run_s("s_load7",        1, 7, 0, 0, 0,  7, 0);
    run_s("s_up_sat",       0, 0, 1, 1, 5,  9, 1);
    run_s("s_up_sat_again", 0, 0, 1, 1, 5,  9, 1);
    run_s("s_dn_clamp",     0, 0, 1, 0, 15, 0, 0);
    run_s("s_dn_at_zero",   0, 0, 1, 0, 1,  0, 1);
    run_s("s_idle",         0, 0, 0, 0, 0,  0, 0);
    run_s("s_load5",        1, 5, 0, 0, 0,  5, 0);
    run_s("s_dn_partial",   0, 0, 1, 0, 2,  3, 0);
    run_s("s_dn_sat",       0, 0, 1, 0, 6,  0, 1);
    run_s("s_up_step0",     0, 0, 1, 1, 0,  0, 0);
    run_s("s_ld_over",      1, 15, 1, 0, 1, 9, 0);

    // Full-range 8-bit wrap against a modular reference model
    m = 0;
    for (int i = 0; i < 300; i++) begin
      u  = bit'($urandom_range(0, 1));
      e  = ($urandom_range(0, 7) != 0);
      st = int'($urandom_range(0, 255));
      eo = 1'b0;
      if (e) begin
        if (u) begin
          t  = m + st;
          eo = (t > 255);
          m  = t % 256;
        end else begin
          t  = m - st;
          eo = (t < 0);
          m  = (t + 256) % 256;
        end
      end
      drv_8(0, 0, e, u, st);
      push($sformatf("full_rand_%0d", i), m, eo, m == 0, m == 255);
      tick();
      check(int'(b8.count), b8.ovf, b8.zero, b8.at_max);
    end

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
